// File: rtl/snvs_lp_zmk_ctrl_pkg.sv
// snvs_lp_zmk_ctrl_pkg: shared widths, state encoding and word-strobe helper for the ZMK controller
package snvs_lp_zmk_ctrl_pkg;
  localparam int SNVS_DATA_WIDTH = 32;
  localparam int SNVS_ZMK_WIDTH = 256;
  localparam logic [SNVS_DATA_WIDTH-1:0] SNVS_DATA_WIDTH_ZERO = '0;
  localparam int ZMK_NUM_WORDS = SNVS_ZMK_WIDTH / SNVS_DATA_WIDTH;
  localparam int ZMK_IDX_W = $clog2(ZMK_NUM_WORDS);
  typedef enum logic [2:0] {
    ZMK_ST_IDLE       = 3'd0,
    ZMK_ST_HW_LOAD    = 3'd1,
    ZMK_ST_ZERO_PULSE = 3'd2,
    ZMK_ST_ZERO_CHECK = 3'd3,
    ZMK_ST_ZERO_FAIL  = 3'd4
  } zmk_st_e;
  function automatic logic [ZMK_NUM_WORDS-1:0] zmk_onehot(input logic [ZMK_IDX_W-1:0] idx);
    return {{(ZMK_NUM_WORDS-1){1'b0}}, 1'b1} << idx;
  endfunction
endpackage

// File: rtl/snvs_lp_zmk_ctrl.sv
// snvs_lp_zmk_ctrl: arbitrates zeroize, HW key load and SW writes onto the ZMK bank and verifies zeroization
module snvs_lp_zmk_ctrl
  import snvs_lp_zmk_ctrl_pkg::*;
#(
  parameter int ZERO_RETRY = 3
) (
  input  logic                       ipg_clk,
  input  logic                       ipg_reset_b,
  input  logic                       sw_wr_req,
  input  logic [ZMK_IDX_W-1:0]       sw_wr_idx,
  input  logic [SNVS_DATA_WIDTH-1:0] lp_wdata,
  input  logic                       zmk_lock,
  input  logic                       hw_key_valid,
  input  logic [SNVS_DATA_WIDTH-1:0] hw_key_data,
  output logic                       hw_key_ready,
  input  logic                       hw_load_start,
  input  logic                       zeroize_req,
  input  logic [SNVS_ZMK_WIDTH-1:0]  lpzmk_reg,
  output logic [ZMK_NUM_WORDS-1:0]   write_lpzmk,
  output logic [SNVS_DATA_WIDTH-1:0] zmk_wdata,
  output logic                       zmk_soft_reset,
  output logic                       zmk_valid,
  output logic                       zmk_hwp,
  output logic                       zmk_busy,
  output logic                       sw_wr_err,
  output logic                       zero_fail
);
  localparam int RW = ZERO_RETRY > 1 ? $clog2(ZERO_RETRY) : 1;
  localparam logic [RW-1:0] RETRY_LAST = RW'(ZERO_RETRY - 1);
  zmk_st_e st;
  logic [ZMK_IDX_W-1:0] ptr;
  logic [ZMK_NUM_WORDS-1:0] mask, sw_mask;
  logic [RW-1:0] retry;
  logic rdy_q, sw_ok, zero_go;
  assign sw_ok = sw_wr_req && st == ZMK_ST_IDLE && !zmk_lock && !zmk_hwp && !zeroize_req && !hw_load_start;
  assign sw_mask = mask | zmk_onehot(sw_wr_idx);
  assign zero_go = zeroize_req && (st == ZMK_ST_IDLE || st == ZMK_ST_HW_LOAD);
  // ready is masked by zeroize so a word dropped by the pre-emption is never seen as accepted
  assign hw_key_ready = rdy_q && !zeroize_req;
  always_ff @(posedge ipg_clk or negedge ipg_reset_b)
    if (!ipg_reset_b) begin
      st <= ZMK_ST_IDLE;
      ptr <= '0;
      mask <= '0;
      retry <= '0;
      rdy_q <= 1'b0;
      write_lpzmk <= '0;
      zmk_wdata <= SNVS_DATA_WIDTH_ZERO;
      zmk_soft_reset <= 1'b0;
      zmk_valid <= 1'b0;
      zmk_hwp <= 1'b0;
      zmk_busy <= 1'b0;
      sw_wr_err <= 1'b0;
      zero_fail <= 1'b0;
    end else begin
      write_lpzmk <= '0;
      zmk_soft_reset <= 1'b0;
      sw_wr_err <= sw_wr_req && !sw_ok;
      if (zero_go) begin
        st <= ZMK_ST_ZERO_PULSE;
        zmk_soft_reset <= 1'b1;
        mask <= '0;
        zmk_hwp <= 1'b0;
        zmk_valid <= 1'b0;
        zmk_busy <= 1'b1;
        rdy_q <= 1'b0;
      end else
        case (st)
          ZMK_ST_IDLE:
            if (hw_load_start) begin
              st <= ZMK_ST_HW_LOAD;
              ptr <= '0;
              rdy_q <= 1'b1;
              zmk_busy <= 1'b1;
            end else if (sw_ok) begin
              write_lpzmk <= zmk_onehot(sw_wr_idx);
              zmk_wdata <= lp_wdata;
              mask <= sw_mask;
              zmk_valid <= &sw_mask;
            end
          ZMK_ST_HW_LOAD:
            if (hw_key_valid) begin
              write_lpzmk <= zmk_onehot(ptr);
              zmk_wdata <= hw_key_data;
              ptr <= ptr + 1'b1;
              if (&ptr) begin
                st <= ZMK_ST_IDLE;
                rdy_q <= 1'b0;
                zmk_busy <= 1'b0;
                zmk_hwp <= 1'b1;
                mask <= '1;
                zmk_valid <= 1'b1;
              end
            end
          ZMK_ST_ZERO_PULSE: st <= ZMK_ST_ZERO_CHECK;
          ZMK_ST_ZERO_CHECK:
            if (!(|lpzmk_reg)) begin
              st <= ZMK_ST_IDLE;
              retry <= '0;
              zmk_busy <= 1'b0;
            end else if (retry < RETRY_LAST) begin
              retry <= retry + 1'b1;
              st <= ZMK_ST_ZERO_PULSE;
              zmk_soft_reset <= 1'b1;
            end else begin
              st <= ZMK_ST_ZERO_FAIL;
              zero_fail <= 1'b1;
            end
          default: ;
        endcase
    end
endmodule

// File: tb/tb_snvs_lp_zmk_ctrl.sv
// tb_snvs_lp_zmk_ctrl: vector table, directed corner sequences and random traffic against a word-level model
module tb_snvs_lp_zmk_ctrl;
  localparam int ZERO_RETRY = 3;
  logic ipg_clk = 1'b0, ipg_reset_b = 1'b0;
  logic sw_wr_req = 1'b0, zmk_lock = 1'b0, hw_key_valid = 1'b0, hw_load_start = 1'b0, zeroize_req = 1'b0;
  logic [2:0] sw_wr_idx = '0;
  logic [31:0] lp_wdata = '0, hw_key_data = '0, zmk_wdata;
  logic [255:0] lpzmk_reg, bank;
  logic [7:0] write_lpzmk;
  logic hw_key_ready, zmk_soft_reset, zmk_valid, zmk_hwp, zmk_busy, sw_wr_err, zero_fail;
  logic stuck = 1'b0;
  int n_chk = 0, n_err = 0;

  snvs_lp_zmk_ctrl #(.ZERO_RETRY(ZERO_RETRY)) dut (
    .ipg_clk(ipg_clk), .ipg_reset_b(ipg_reset_b), .sw_wr_req(sw_wr_req), .sw_wr_idx(sw_wr_idx),
    .lp_wdata(lp_wdata), .zmk_lock(zmk_lock), .hw_key_valid(hw_key_valid), .hw_key_data(hw_key_data),
    .hw_key_ready(hw_key_ready), .hw_load_start(hw_load_start), .zeroize_req(zeroize_req),
    .lpzmk_reg(lpzmk_reg), .write_lpzmk(write_lpzmk), .zmk_wdata(zmk_wdata),
    .zmk_soft_reset(zmk_soft_reset), .zmk_valid(zmk_valid), .zmk_hwp(zmk_hwp), .zmk_busy(zmk_busy),
    .sw_wr_err(sw_wr_err), .zero_fail(zero_fail));

  always #5 ipg_clk = ~ipg_clk;

  // ZMK bank stand-in; stuck forces a bit that soft reset cannot clear
  always_ff @(posedge ipg_clk or negedge ipg_reset_b)
    if (!ipg_reset_b) bank <= '0;
    else if (zmk_soft_reset) bank <= '0;
    else for (int i = 0; i < 8; i++) if (write_lpzmk[i]) bank[i*32+:32] <= zmk_wdata;
  assign lpzmk_reg = bank | {255'b0, stuck};

  // reference model: activity mode, words written, retry attempts, expected key words
  int m_mode, m_ptr, m_tries;
  bit [7:0] m_written, e_wr;
  bit m_hwp, e_srst, e_err;
  bit [31:0] e_wd, m_key[8];

  function automatic logic [255:0] key_vec();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32+:32] = m_key[i];
    return v;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_ptr = 0; m_tries = 0; m_written = '0; m_hwp = 0;
    e_wr = '0; e_srst = 0; e_err = 0; e_wd = '0;
    for (int i = 0; i < 8; i++) m_key[i] = '0;
  endtask

  task automatic start_zero();
    m_mode = 2; e_srst = 1; m_written = '0; m_hwp = 0;
  endtask

  task automatic model(input logic [255:0] seen);
    if (e_srst) for (int i = 0; i < 8; i++) m_key[i] = '0;
    for (int i = 0; i < 8; i++) if (e_wr[i]) m_key[i] = e_wd;
    e_wr = '0; e_srst = 0; e_err = sw_wr_req;
    if (m_mode == 0) begin
      if (zeroize_req) start_zero();
      else if (hw_load_start) begin m_mode = 1; m_ptr = 0; end
      else if (sw_wr_req && !zmk_lock && !m_hwp) begin
        e_err = 0; e_wr[sw_wr_idx] = 1; e_wd = lp_wdata; m_written[sw_wr_idx] = 1;
      end
    end else if (m_mode == 1) begin
      if (zeroize_req) start_zero();
      else if (hw_key_valid) begin
        e_wr[m_ptr] = 1; e_wd = hw_key_data; m_ptr++;
        if (m_ptr == 8) begin m_mode = 0; m_hwp = 1; m_written = '1; end
      end
    end else if (m_mode == 2) m_mode = 3;
    else if (m_mode == 3) begin
      if (seen == '0) begin m_mode = 0; m_tries = 0; end
      else begin
        m_tries++;
        if (m_tries < ZERO_RETRY) start_zero(); else m_mode = 4;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    logic [255:0] seen;
    seen = lpzmk_reg;
    @(posedge ipg_clk);
    model(seen);
    #1;
    chk("write_lpzmk", write_lpzmk, e_wr);
    if (e_wr != 0) chk("zmk_wdata", zmk_wdata, e_wd);
    chk("zmk_soft_reset", zmk_soft_reset, e_srst);
    chk("zmk_valid", zmk_valid, &m_written);
    chk("zmk_hwp", zmk_hwp, m_hwp);
    chk("zmk_busy", zmk_busy, m_mode != 0);
    chk("sw_wr_err", sw_wr_err, e_err);
    chk("zero_fail", zero_fail, m_mode == 4);
    chk("hw_key_ready", hw_key_ready, m_mode == 1 && !zeroize_req);
    chk("bank", lpzmk_reg, key_vec() | {255'b0, stuck});
  endtask

  task automatic do_reset();
    ipg_reset_b = 1'b0;
    #1;
    model_reset();
    chk("rst_outs", {write_lpzmk, zmk_wdata, zmk_soft_reset, zmk_valid, zmk_hwp, zmk_busy, sw_wr_err, zero_fail, hw_key_ready}, '0);
    @(posedge ipg_clk);
    #1;
    ipg_reset_b = 1'b1;
  endtask

  typedef struct {
    bit req; bit [2:0] idx; bit [31:0] d; bit lock;
    bit [7:0] ewr; bit eerr; bit evalid;
  } vec_t;
  vec_t tv[10];
  logic [255:0] exp_key;
  int pulses;

  initial begin
    for (int i = 0; i < 8; i++) tv[i] = '{1'b1, 3'(i), 32'h1111_1111 * (i + 1), 1'b0, 8'b1 << i, 1'b0, i == 7};
    tv[8] = '{1'b1, 3'd3, 32'hDEAD_BEEF, 1'b1, 8'h00, 1'b1, 1'b1};
    tv[9] = '{1'b0, 3'd0, 32'h0, 1'b0, 8'h00, 1'b0, 1'b1};
    do_reset();
    // SW writes, then a locked write, from the vector table
    for (int k = 0; k < 10; k++) begin
      sw_wr_req = tv[k].req; sw_wr_idx = tv[k].idx; lp_wdata = tv[k].d; zmk_lock = tv[k].lock;
      tick();
      chk("tv_strobe", write_lpzmk, tv[k].ewr);
      chk("tv_err", sw_wr_err, tv[k].eerr);
      chk("tv_valid", zmk_valid, tv[k].evalid);
    end
    for (int i = 0; i < 8; i++) exp_key[i*32+:32] = 32'h1111_1111 * (i + 1);
    chk("sw_key", lpzmk_reg, exp_key);
    // all three requesters at once: zeroize wins
    zeroize_req = 1; hw_load_start = 1; sw_wr_req = 1; sw_wr_idx = 3'd2;
    tick();
    chk("sim_srst", zmk_soft_reset, 1'b1);
    chk("sim_err", sw_wr_err, 1'b1);
    zeroize_req = 0; hw_load_start = 0; sw_wr_req = 0;
    tick(); tick();
    chk("sim_idle", zmk_busy, 1'b0);
    chk("sim_key", lpzmk_reg, '0);
    // HW load with a two-cycle gap after word 3
    hw_load_start = 1; tick(); hw_load_start = 0;
    chk("hw_ready", hw_key_ready, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin hw_key_valid = 0; tick(); chk("hw_gap", write_lpzmk, '0); tick(); end
      hw_key_valid = 1; hw_key_data = 32'hA5A5_0000 + i;
      tick();
      chk("hw_strobe", write_lpzmk, 8'b1 << i);
      chk("hw_wdata", zmk_wdata, 32'hA5A5_0000 + i);
    end
    hw_key_valid = 0; tick();
    for (int i = 0; i < 8; i++) exp_key[i*32+:32] = 32'hA5A5_0000 + i;
    chk("hw_key", lpzmk_reg, exp_key);
    chk("hw_hwp", zmk_hwp, 1'b1);
    chk("hw_valid", zmk_valid, 1'b1);
    sw_wr_req = 1; sw_wr_idx = 3'd0; lp_wdata = 32'h1234_5678;
    tick(); sw_wr_req = 0;
    chk("hwp_sw_err", sw_wr_err, 1'b1);
    chk("hwp_sw_nostrobe", write_lpzmk, '0);
    // zeroize pre-empts HW word 5
    hw_load_start = 1; tick(); hw_load_start = 0;
    for (int i = 0; i < 5; i++) begin hw_key_valid = 1; hw_key_data = 32'h5A5A_0000 + i; tick(); end
    hw_key_data = 32'h5A5A_0005; zeroize_req = 1;
    #1;
    chk("abort_ready", hw_key_ready, 1'b0);
    tick();
    chk("abort_nostrobe", write_lpzmk, '0);
    chk("abort_srst", zmk_soft_reset, 1'b1);
    zeroize_req = 0; hw_key_valid = 0;
    tick(); tick();
    chk("abort_key", lpzmk_reg, '0);
    chk("abort_hwp", zmk_hwp, 1'b0);
    chk("abort_busy", zmk_busy, 1'b0);
    // stuck bank: retries exhaust into the failure state
    stuck = 1; zeroize_req = 1; tick(); zeroize_req = 0;
    pulses = int'(zmk_soft_reset);
    for (int c = 0; c < 20; c++) begin tick(); pulses += int'(zmk_soft_reset); end
    chk("stuck_pulses", pulses, ZERO_RETRY);
    chk("stuck_fail", zero_fail, 1'b1);
    chk("stuck_busy", zmk_busy, 1'b1);
    sw_wr_req = 1; tick(); sw_wr_req = 0;
    chk("stuck_sw_err", sw_wr_err, 1'b1);
    stuck = 0;
    do_reset();
    // random traffic against the model
    for (int c = 0; c < 800; c++) begin
      zeroize_req = $urandom_range(0, 39) == 0;
      hw_load_start = $urandom_range(0, 14) == 0;
      sw_wr_req = $urandom_range(0, 2) == 0;
      sw_wr_idx = 3'($urandom_range(0, 7));
      lp_wdata = $urandom;
      zmk_lock = $urandom_range(0, 9) == 0;
      hw_key_valid = $urandom_range(0, 1) == 1;
      hw_key_data = $urandom;
      if ($urandom_range(0, 299) == 0) do_reset(); else tick();
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
